// File: rtl/axi_sim_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel state enums and the
// byte-lane merge used by the write commit.
package axi_sim_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite bus bundle between the M00_AXI master and the slave memory.
interface axi_lite_slave_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave register-array memory: byte-enabled writes, one outstanding
// write and one outstanding read, SLVERR and a saturating error count.
module axi_lite_slave_mem
  import axi_sim_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_WORDS          = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  axi_lite_slave_mem_if.slave   s_axi,
  output logic [7:0]            ERR_COUNT
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int WIDX_W = C_S_AXI_ADDR_WIDTH - 2;

  typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

  wr_state_t                     wr_state_q, wr_state_d;
  rd_state_t                     rd_state_q, rd_state_d;
  logic                          aw_held_q, aw_held_d;
  logic                          w_held_q, w_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  word_t                         wdata_q, wdata_d;
  logic [3:0]                    wstrb_q, wstrb_d;
  logic [1:0]                    bresp_q, bresp_d;
  word_t                         rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [7:0]                    err_q, err_d;
  word_t                         mem_q [NUM_WORDS];
  word_t                         mem_d [NUM_WORDS];

  logic              aw_hs, w_hs, ar_hs, commit;
  logic              w_oor, r_oor;
  logic [WIDX_W-1:0] widx, ridx;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;

  assign widx  = awaddr_q[C_S_AXI_ADDR_WIDTH-1:2];
  assign ridx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_oor = 32'(widx) >= NUM_WORDS;
  assign r_oor = 32'(ridx) >= NUM_WORDS;

  assign aw_hs  = (wr_state_q == W_IDLE) && !aw_held_q && s_axi.S_AXI_AWVALID;
  assign w_hs   = (wr_state_q == W_IDLE) && !w_held_q && s_axi.S_AXI_WVALID;
  assign commit = (wr_state_q == W_IDLE) && aw_held_q && w_held_q;
  assign ar_hs  = (rd_state_q == R_IDLE) && s_axi.S_AXI_ARVALID;

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    mem_d      = mem_q;
    err_inc    = 2'd0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi.S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end

    if (commit) begin
      aw_held_d  = 1'b0;
      w_held_d   = 1'b0;
      wr_state_d = W_RESP;
      bresp_d    = w_oor ? RESP_SLVERR : RESP_OKAY;
      if (!w_oor) mem_d[widx[IDX_W-1:0]] = wstrb_merge(mem_q[widx[IDX_W-1:0]], wdata_q, wstrb_q);
      if (w_oor) err_inc = err_inc + 2'd1;
    end else if ((wr_state_q == W_RESP) && s_axi.S_AXI_BREADY) begin
      wr_state_d = W_IDLE;
    end

    // Read samples mem_q, so a same-edge commit to that word is not yet visible.
    if (ar_hs) begin
      rd_state_d = R_RESP;
      rdata_d    = r_oor ? '0 : mem_q[ridx[IDX_W-1:0]];
      rresp_d    = r_oor ? RESP_SLVERR : RESP_OKAY;
      if (r_oor) err_inc = err_inc + 2'd1;
    end else if ((rd_state_q == R_RESP) && s_axi.S_AXI_RREADY) begin
      rd_state_d = R_IDLE;
    end

    err_sum = {1'b0, err_q} + {7'b0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      err_q      <= '0;
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = (wr_state_q == W_IDLE) && !aw_held_q;
  assign s_axi.S_AXI_WREADY  = (wr_state_q == W_IDLE) && !w_held_q;
  assign s_axi.S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = (rd_state_q == R_IDLE);
  assign s_axi.S_AXI_RVALID  = (rd_state_q == R_RESP);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign ERR_COUNT           = err_q;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         awaddr_q[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem: handshakes, byte enables, SLVERR,
// back-pressure, read/write collision, error-count saturation and reset.
module tb_axi_lite_slave_mem;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [7:0] ERR_COUNT;
  int         checks = 0;
  int         failures = 0;
  logic [31:0] rd_data;
  logic [1:0]  resp;

  axi_lite_slave_mem_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  axi_lite_slave_mem #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(8),
    .NUM_WORDS(16)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .s_axi(bus.slave),
    .ERR_COUNT(ERR_COUNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(output logic [1:0] r);
    bit seen = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      @(negedge ACLK);
      seen = bus.S_AXI_BVALID;
    end
    chk("b_seen", 32'(seen), 32'd1);
    r = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic wr_txn(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] r);
    @(negedge ACLK);
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    wait_b(r);
  endtask

  task automatic rd_txn(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    bit seen = 1'b0;
    @(negedge ACLK);
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      if (n > 0) @(negedge ACLK);
      seen = bus.S_AXI_RVALID;
    end
    chk("r_seen", 32'(seen), 32'd1);
    d = bus.S_AXI_RDATA;
    r = bus.S_AXI_RRESP;
    @(posedge ACLK); #1;
  endtask

  initial begin
    ARESET = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = 3'b0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = 3'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // Reset state
    @(negedge ACLK);
    chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    chk("rst_wready",  32'(bus.S_AXI_WREADY),  32'd1);
    chk("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    chk("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    chk("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    chk("rst_rdata",   bus.S_AXI_RDATA,        32'h0);
    chk("rst_err",     32'(ERR_COUNT),         32'd0);

    // AW and W in the same cycle: B one edge after the handshake edge
    bus.S_AXI_AWADDR = 8'h04; bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    chk("same_awready_low", 32'(bus.S_AXI_AWREADY), 32'd0);
    chk("same_wready_low",  32'(bus.S_AXI_WREADY),  32'd0);
    chk("same_bvalid_early", 32'(bus.S_AXI_BVALID), 32'd0);
    @(negedge ACLK);
    chk("same_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    chk("same_bresp",  32'(bus.S_AXI_BRESP),  32'd0);
    @(negedge ACLK);
    chk("same_bvalid_done", 32'(bus.S_AXI_BVALID),  32'd0);
    chk("same_awready_back", 32'(bus.S_AXI_AWREADY), 32'd1);
    rd_txn(8'h04, rd_data, resp);
    chk("rd04_data", rd_data, 32'hDEADBEEF);
    chk("rd04_resp", 32'(resp), 32'd0);

    // W three cycles ahead of AW
    @(negedge ACLK);
    bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("wfirst_wready_low", 32'(bus.S_AXI_WREADY),  32'd0);
      chk("wfirst_awready",    32'(bus.S_AXI_AWREADY), 32'd1);
      chk("wfirst_no_b",       32'(bus.S_AXI_BVALID),  32'd0);
    end
    bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    chk("wfirst_b_early", 32'(bus.S_AXI_BVALID), 32'd0);
    @(negedge ACLK);
    chk("wfirst_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    chk("wfirst_bresp",  32'(bus.S_AXI_BRESP),  32'd0);
    @(posedge ACLK); #1;
    rd_txn(8'h08, rd_data, resp);
    chk("rd08_data", rd_data, 32'h12345678);

    // Byte enables 0101 over 0x11223344
    wr_txn(8'h0C, 32'h11223344, 4'hF, resp);
    wr_txn(8'h0C, 32'hAABBCCDD, 4'b0101, resp);
    chk("strb_bresp", 32'(resp), 32'd0);
    rd_txn(8'h0C, rd_data, resp);
    chk("strb_data", rd_data, 32'h11BB33DD);

    // WSTRB=0 in range: OKAY, no change
    wr_txn(8'h04, 32'hFFFFFFFF, 4'h0, resp);
    chk("strb0_bresp", 32'(resp), 32'd0);
    rd_txn(8'h04, rd_data, resp);
    chk("strb0_data", rd_data, 32'hDEADBEEF);

    // Last valid word and first out-of-range word
    wr_txn(8'h3D, 32'hCAFEF00D, 4'hF, resp);
    chk("last_bresp", 32'(resp), 32'd0);
    rd_txn(8'h3C, rd_data, resp);
    chk("last_data", rd_data, 32'hCAFEF00D);
    wr_txn(8'h40, 32'h55555555, 4'hF, resp);
    chk("oor_bresp", 32'(resp), 32'd2);
    chk("oor_err1",  32'(ERR_COUNT), 32'd1);
    rd_txn(8'h40, rd_data, resp);
    chk("oor_rdata", rd_data, 32'h0);
    chk("oor_rresp", 32'(resp), 32'd2);
    chk("oor_err2",  32'(ERR_COUNT), 32'd2);
    rd_txn(8'h00, rd_data, resp);
    chk("oor_word0", rd_data, 32'h0);

    // Back-pressure with a same-word collision: read sees pre-write data
    @(negedge ACLK);
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_AWADDR = 8'h0C; bus.S_AXI_WDATA = 32'h99887766; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    bus.S_AXI_ARADDR = 8'h0C; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_WDATA = 32'hFFFFFFFF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_ARADDR = 8'h04;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("stall_bvalid",  32'(bus.S_AXI_BVALID),  32'd1);
      chk("stall_bresp",   32'(bus.S_AXI_BRESP),   32'd0);
      chk("stall_rvalid",  32'(bus.S_AXI_RVALID),  32'd1);
      chk("stall_rdata",   bus.S_AXI_RDATA,        32'h11BB33DD);
      chk("stall_rresp",   32'(bus.S_AXI_RRESP),   32'd0);
      chk("stall_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
      chk("stall_wready",  32'(bus.S_AXI_WREADY),  32'd0);
      chk("stall_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("release_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    chk("release_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    chk("release_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    chk("release_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    rd_txn(8'h0C, rd_data, resp);
    chk("post_commit_data", rd_data, 32'h99887766);
    rd_txn(8'h00, rd_data, resp);
    chk("refused_aw_word0", rd_data, 32'h0);

    // Both paths raise SLVERR on the same edge: +2
    @(negedge ACLK);
    bus.S_AXI_AWADDR = 8'h44; bus.S_AXI_WDATA = 32'h1; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    bus.S_AXI_ARADDR = 8'h48; bus.S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("dual_bresp", 32'(bus.S_AXI_BRESP), 32'd2);
    chk("dual_rresp", 32'(bus.S_AXI_RRESP), 32'd2);
    chk("dual_err",   32'(ERR_COUNT),       32'd4);
    @(posedge ACLK); #1;

    // Saturation at 255
    for (int i = 0; i < 255; i++) rd_txn(8'h40, rd_data, resp);
    chk("err_sat", 32'(ERR_COUNT), 32'd255);

    // Reset while BVALID and RVALID are both pending
    @(negedge ACLK);
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_WDATA = 32'h00000001; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 8'h04;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("pre_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    chk("pre_rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    chk("mid_rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    chk("mid_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    chk("mid_rst_wready",  32'(bus.S_AXI_WREADY),  32'd1);
    chk("mid_rst_arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    chk("mid_rst_err",     32'(ERR_COUNT),         32'd0);
    chk("mid_rst_rdata",   bus.S_AXI_RDATA,        32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_txn(8'(i * 4), rd_data, resp);
      chk("mid_rst_word", rd_data, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
